// File: rtl/sram_pkg.sv
// Shared constants, enums and elaboration-time legality helpers for the byte-enable SRAM.
package sram_pkg;

  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

  localparam int unsigned MODE_READ_FIRST  = 0;
  localparam int unsigned MODE_WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  function automatic int unsigned num_bytes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

  function automatic bit data_width_ok(input int unsigned data_width,
                                       input int unsigned byte_width);
    return (byte_width != 0) && (data_width != 0) && ((data_width % byte_width) == 0);
  endfunction

  function automatic bit depth_ok(input int unsigned depth, input int unsigned addr_width);
    return (depth != 0) && (64'(depth) <= (64'd1 << addr_width));
  endfunction

  function automatic bit read_latency_ok(input int unsigned read_latency);
    return (read_latency == RD_LAT_1) || (read_latency == RD_LAT_2);
  endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Read/write/busy bundle of the byte-enable SRAM; names mirror the memory's own port list.
interface sram_dp_be_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8
);

  localparam int unsigned NUM_BYTES = sram_pkg::num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                  i_readEnable;
  logic [ADDR_WIDTH-1:0] i_readAddr;
  logic [DATA_WIDTH-1:0] o_dataOut;
  logic                  o_readValid;
  logic                  i_writeEnable;
  logic [NUM_BYTES-1:0]  i_byteEnable;
  logic [ADDR_WIDTH-1:0] i_writeAddr;
  logic [DATA_WIDTH-1:0] i_dataIn;
  logic                  o_busy;

  modport master (
    output i_readEnable, i_readAddr, i_writeEnable, i_byteEnable, i_writeAddr, i_dataIn,
    input  o_dataOut, o_readValid, o_busy
  );

  modport slave (
    input  i_readEnable, i_readAddr, i_writeEnable, i_byteEnable, i_writeAddr, i_dataIn,
    output o_dataOut, o_readValid, o_busy
  );

endinterface

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, one word per cycle, then idles.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  busy_o,
  output logic                  clear_we_o,
  output logic [ADDR_WIDTH-1:0] clear_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam clr_state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clear_we_o = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      StClear: begin
        busy_o     = 1'b1;
        clear_we_o = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign clear_addr_o = cnt_q;

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with per-byte write enables, selectable read-during-write
// behaviour, 1/2-cycle read pipeline and a post-reset auto-clear.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           DEPTH          = 256,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           BYTE_WIDTH     = 8,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter int unsigned           WRITE_FIRST    = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input logic         i_clk,
  input logic         i_reset,
  sram_dp_be_if.slave bus
);

  localparam int unsigned           NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned           IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  if (!data_width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : gen_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if (!depth_ok(DEPTH, ADDR_WIDTH)) begin : gen_bad_depth
    $error("DEPTH must be non-zero and no larger than 2**ADDR_WIDTH");
  end
  if (!read_latency_ok(READ_LATENCY)) begin : gen_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic                  busy;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  sram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .busy_o       (busy),
    .clear_we_o   (clear_we),
    .clear_addr_o (clear_addr)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: the clear sequencer owns it while busy, user writes are dropped.
  logic                  wr_en;
  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  wr_be;

  always_comb begin
    if (busy) begin
      wr_en   = clear_we;
      wr_addr = clear_addr;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end else begin
      wr_en   = bus.i_writeEnable;
      wr_addr = bus.i_writeAddr;
      wr_data = bus.i_dataIn;
      wr_be   = bus.i_byteEnable;
    end
    wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (wr_ok && wr_be[k]) begin
        mem_q[wr_addr[IDX_W-1:0]][k*BYTE_WIDTH +: BYTE_WIDTH] <=
            wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic                  rd_accept;
  logic                  rd_in_range;
  logic                  rd_collide;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_accept   = !busy && bus.i_readEnable;
    rd_in_range = {1'b0, bus.i_readAddr} < DEPTH_LIM;
    rd_collide  = wr_ok && (wr_addr == bus.i_readAddr);
    rd_word     = mem_q[bus.i_readAddr[IDX_W-1:0]];
    // Write-first forwards only the lanes being written; the rest come from the array.
    if (WRITE_FIRST == MODE_WRITE_FIRST && rd_collide) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (wr_be[k]) begin
          rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (!rd_in_range) begin
      rd_word = '0;
    end
  end

  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (READ_LATENCY == RD_LAT_2) begin : gen_lat2
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_valid_q;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign bus.o_dataOut   = s2_data_q;
    assign bus.o_readValid = s2_valid_q;
  end else begin : gen_lat1
    assign bus.o_dataOut   = s1_data_q;
    assign bus.o_readValid = s1_valid_q;
  end

  assign bus.o_busy = busy;

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Single-clock simple-dual-port SRAM with per-byte write enables, selectable read-during-write behaviour and 1- or 2-cycle read latency with a valid flag. After reset it can auto-clear every word to a fixed value, with a busy flag. It is the general-purpose storage block for the VGA pipeline: line buffers, palette RAM and sprite tables.

Parameters:
ADDR_WIDTH, 8, width of the read and write address ports.
DEPTH, 256, number of words. Must be ≤ 2**ADDR_WIDTH.
DATA_WIDTH, 8, word width. Must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, lane width for byte enables. NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, read latency in cycles; legal values are 1 or 2.
WRITE_FIRST, 0, read-during-write mode for the same address: 1 = new data, 0 = old data.
CLEAR_ON_RESET, 1, 1 = write INIT_VALUE to every word after reset.
INIT_VALUE, 0, DATA_WIDTH-wide value used by the clear sequence.

Ports:
i_clk  in  1  single clock; all logic on its rising edge.
i_reset  in  1  reset; synchronous and active-high.
i_readEnable  in  1  read request this cycle.
i_readAddr  in  ADDR_WIDTH  read address.
o_dataOut  out  DATA_WIDTH  read data.
o_readValid  out  1  o_dataOut holds the result of an accepted read.
i_writeEnable  in  1  write request this cycle.
i_byteEnable  in  NUM_BYTES  lane mask; bit k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH].
i_writeAddr  in  ADDR_WIDTH  write address.
i_dataIn  in  DATA_WIDTH  write data.
o_busy  out  1  clear sequence in progress; all requests are ignored.

Behaviour:
- Reset (i_reset high at an edge):
  - o_dataOut=0, o_readValid=0, all pipeline stages cleared, clear counter=0.
  - o_busy=1 if CLEAR_ON_RESET, else 0.
  - Memory contents are untouched by reset itself.
- FSM states: IDLE, CLEAR.
  - Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
  - In CLEAR, one word is written per cycle: mem[cnt] <= INIT_VALUE, cnt increments.
  - After the write of DEPTH-1 the FSM moves to IDLE. o_busy is high for exactly DEPTH cycles after reset is released.
  - Reset asserted mid-clear restarts the sequence at address 0.
- While o_busy=1: writes are dropped, reads are not accepted, o_readValid stays 0.
- Write (IDLE, i_writeEnable=1, i_writeAddr<DEPTH):
  - Lane k is updated only if i_byteEnable[k]=1.
  - An all-zero mask is a no-op.
  - Addresses ≥ DEPTH are ignored.
- Read (IDLE, i_readEnable=1), READ_LATENCY=1:
  - Request sampled at edge N; o_dataOut and o_readValid=1 are updated at edge N.
  - At the next edge with no accepted read, o_readValid drops to 0.
  - o_dataOut holds its last value when no read is accepted.
- READ_LATENCY=2: one extra output register stage. Data and valid appear one edge later and both shift together.
- Back-to-back reads give one result per cycle with no bubbles.
- Read address ≥ DEPTH: the read is accepted, data is 0, valid is asserted.
- Same-address read and write in the same cycle:
  - WRITE_FIRST=1: per lane, enabled lanes return i_dataIn and disabled lanes return stored data.
  - WRITE_FIRST=0: the fully old word is returned.
- Different-address read and write in the same cycle are independent.

Decomposition:
- Shared package sram_pkg holds:
  - constants RD_LAT_1=1 and RD_LAT_2=2;
  - constants MODE_READ_FIRST=0 and MODE_WRITE_FIRST=1;
  - function num_bytes(DATA_WIDTH, BYTE_WIDTH);
  - elaboration-time parameter legality checks: DATA_WIDTH divisibility, DEPTH bound, READ_LATENCY ∈ {1,2}.
- One natural sub-module, sram_clear_seq, owns the CLEAR/IDLE FSM and address counter. It outputs busy, clear_we and clear_addr, which the top muxes into the write port ahead of user writes.

Test Plan:
- Clear sequence, DEPTH=16: release reset → o_busy=1 for exactly 16 cycles. Then reads of addresses 0..15 all return INIT_VALUE with o_readValid=1.
- Byte enables, DATA_WIDTH=32, BYTE_WIDTH=8: write 0x11223344 to addr 5 with mask 4'b1111, then 0xAABBCCDD with mask 4'b0101 → read of addr 5 returns 0x11BB33DD.
- Collision, addr 7 holding 0x00, write 0xFF with full mask and read addr 7 in the same cycle → result 0x00 when WRITE_FIRST=0, 0xFF when WRITE_FIRST=1.
- Latency and streaming, READ_LATENCY=2: read addrs 0,1,2 on consecutive cycles → o_readValid high for exactly 3 consecutive cycles starting 2 edges after the first request, data in address order.
- Busy gating: during clear, assert a write of 0x5A to addr 3 and a read of addr 3 → o_readValid stays 0. After clear, addr 3 reads INIT_VALUE.
- Reset mid-clear, DEPTH=16: assert i_reset at clear cycle 8, release → o_busy high for a full 16 further cycles, and all words equal INIT_VALUE.
